cordic_req_arbiter: RTL and testbench
=====================================

# cordic_req_arbiter

Round-robin arbiter and sequencer that shares one CORDIC sine/cosine unit among `N_REQ` requesters. It captures a requester's angle and operation, then runs the CORDIC start/ready/ack handshake. It returns the result with a one-cycle done strobe and guards against a hung CORDIC with a watchdog. It sits between the client blocks and the CORDIC FSM/datapath.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `W`, default 32: angle/result width in bits.
- `TIMEOUT_CYC`, default 1023: maximum cycles in WAIT before abort, 1..65535.
- `clk` input 1: system clock; everything is on the rising edge.
- `reset` input 1: asynchronous, active-low (0 = reset).
- `req` input N_REQ: per-requester level request. It is held until that requester's `done` bit.
- `req_op` input N_REQ: per-requester operation. 0 = cosine, 1 = sine.
- `req_angle` input N_REQ*W: per-requester angle. Slice i is bits [i*W +: W].
- `done` output N_REQ: one-hot, one-cycle strobe to the served requester.
- `err` output 1: qualifies `done`. 1 = timeout abort, and `result` is invalid.
- `result` output W: captured CORDIC result. Valid while `done` is nonzero, and held until the next capture.
- `cordic_beg` output 1: start pulse to the CORDIC FSM.
- `cordic_op` output 1: registered operation of the granted requester.
- `cordic_angle` output W: registered angle of the granted requester.
- `cordic_ready` input 1: CORDIC result-ready level.
- `cordic_result` input W: CORDIC output data.
- `cordic_ack` output 1: acknowledge to the CORDIC FSM.
- `busy` output 1: high in every state except IDLE.
- `timeout_cnt` output 8: saturating count of aborts.

## Operation
- States, 3-bit encoding:
  - IDLE=0
  - ISSUE=1
  - WAIT=2
  - ACK=3
  - DONE=4
  - Unused codes go to IDLE.
- IDLE:
  - If any `req` bit is set, select a winner round-robin. Search starts at `last_gnt+1` mod N_REQ.
  - Register `gnt`, `cordic_op` and `cordic_angle` from the winner, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - `cordic_beg`=1 for exactly this cycle.
  - Clear the watchdog counter, then go to WAIT.
- WAIT:
  - Increment the watchdog each cycle.
  - If `cordic_ready`=1, load `result` from `cordic_result`, set `err_r`=0, and go to ACK.
  - Otherwise, if the watchdog equals TIMEOUT_CYC, set `err_r`=1, increment `timeout_cnt` (saturating at 255), and go to ACK.
  - Ready has priority over timeout in the same cycle.
- ACK:
  - `cordic_ack`=1 for exactly this cycle, then go to DONE.
  - The ack is issued on the timeout path as well, to free a CORDIC that is parked in its ready state.
- DONE:
  - `done[gnt]`=1 and `err`=`err_r` for this cycle.
  - Set `last_gnt`=`gnt`, then go to IDLE.
- Requester inputs are sampled only in IDLE. Changes after grant are ignored for the current transaction.
- A `req` still high in the IDLE cycle after its `done` counts as a new request. The round-robin pointer then favours other requesters first.
- Dropping `req` after grant does not cancel the transaction; `done` is still issued.
- `last_gnt` resets to N_REQ-1, so requester 0 has first priority after reset.

## Timing
- Reset values:
  - state = IDLE
  - `done`=0, `err`=0, `result`=0
  - `cordic_beg`=0, `cordic_op`=0, `cordic_angle`=0, `cordic_ack`=0
  - `busy`=0, `timeout_cnt`=0
  - watchdog = 0, `last_gnt`=N_REQ-1
- Outputs decode from registered state/data only. There is no input-to-output combinational path.
- Latency:
  - `req` seen in IDLE at cycle t gives `cordic_beg` at t+1.
  - `cordic_ready` seen at cycle r gives `cordic_ack` at r+1 and `done` at r+2.
  - With a CORDIC latency L (beg to ready), `done` comes L+2 cycles after `beg`.
- Back-to-back service: the minimum gap from one `done` to the next `cordic_beg` is 2 cycles (DONE→IDLE→ISSUE).
- Timeout:
  - `cordic_ready` never asserts: `cordic_ack` comes at `beg`+TIMEOUT_CYC+1, and `done` with `err`=1 at `beg`+TIMEOUT_CYC+2.
- Reset asserted in any state:
  - All outputs go to their reset values immediately and asynchronously. No `done` is produced for the aborted transaction.
  - The CORDIC is reset separately by the system.
- Deassertion of `reset` is synchronised externally.

## Test plan
- Single request: `req`=0001, `req_op`=0, angle 0x3F490FDB, CORDIC model latency 40 → `cordic_beg` 1 cycle after `req`, `cordic_op`=0, `cordic_angle`=0x3F490FDB. `done`=0001 at `beg`+42, `err`=0, `result` equal to the model output.
- Fairness: `req`=1111 held continuously, with each requester re-raising right after its `done` → grant order 0,1,2,3,0,1…; no requester is served twice before every other pending one has been served.
- Timeout: TIMEOUT_CYC=15, `cordic_ready` tied 0 → `cordic_ack` at `beg`+16, `done` with `err`=1 at `beg`+17, `timeout_cnt`=1. A following normal request completes with `err`=0.
- Input change after grant: requester 2 changes its angle and drops `req` in the WAIT state → `cordic_angle` keeps the original value, and `done`=0100 is still issued.
- Reset mid-WAIT: assert `reset`=0 while in WAIT → `busy`, `cordic_beg`, `cordic_ack` and `done` are 0 in the same cycle. After release, `req`=0011 is granted to requester 0 first.
- Ready/timeout collision: `cordic_ready` rises on the same cycle the watchdog reaches TIMEOUT_CYC → `err`=0, `result` is captured, and `timeout_cnt` is unchanged.

Source files
------------

// File: rtl/cordic_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one CORDIC unit among N_REQ clients.
// Runs the beg/ready/ack handshake with a watchdog abort on a hung CORDIC.
module cordic_req_arbiter #(
  parameter int N_REQ       = 4,
  parameter int W           = 32,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_op,
  input  logic [N_REQ*W-1:0] req_angle,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic [W-1:0]       result,
  output logic               cordic_beg,
  output logic               cordic_op,
  output logic [W-1:0]       cordic_angle,
  input  logic               cordic_ready,
  input  logic [W-1:0]       cordic_result,
  output logic               cordic_ack,
  output logic               busy,
  output logic [7:0]         timeout_cnt
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  gnt_q, gnt_d;
  logic [GW-1:0]  last_q, last_d;
  logic           op_q, op_d;
  logic [W-1:0]   angle_q, angle_d;
  logic [15:0]    wd_q, wd_d;
  logic [W-1:0]   res_q, res_d;
  logic           err_r_q, err_r_d;
  logic [7:0]     tcnt_q, tcnt_d;

  logic           win_vld;
  logic [GW-1:0]  win_idx;
  logic [15:0]    wd_inc;

  // Nearest requester after last_q wins: scan farthest first so the closest overwrites.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last_q) + k) % N_REQ]) begin
        win_vld = 1'b1;
        win_idx = GW'((int'(last_q) + k) % N_REQ);
      end
    end
  end

  assign wd_inc = wd_q + 16'd1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    op_d    = op_q;
    angle_d = angle_q;
    wd_d    = wd_q;
    res_d   = res_q;
    err_r_d = err_r_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          gnt_d   = win_idx;
          op_d    = req_op[win_idx];
          angle_d = req_angle[win_idx*W +: W];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_inc;
        if (cordic_ready) begin
          res_d   = cordic_result;
          err_r_d = 1'b0;
          state_d = S_ACK;
        end else if (wd_inc == 16'(TIMEOUT_CYC)) begin
          err_r_d = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          state_d = S_ACK;
        end
      end
      // Ack is sent on timeout too, so a CORDIC parked in ready is released.
      S_ACK:  state_d = S_DONE;
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= GW'(N_REQ - 1);
      op_q    <= 1'b0;
      angle_q <= '0;
      wd_q    <= '0;
      res_q   <= '0;
      err_r_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      angle_q <= angle_d;
      wd_q    <= wd_d;
      res_q   <= res_d;
      err_r_q <= err_r_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    done = '0;
    if (state_q == S_DONE) done[gnt_q] = 1'b1;
  end

  assign err          = (state_q == S_DONE) && err_r_q;
  assign result       = res_q;
  assign cordic_beg   = (state_q == S_ISSUE);
  assign cordic_ack   = (state_q == S_ACK);
  assign cordic_op    = op_q;
  assign cordic_angle = angle_q;
  assign busy         = (state_q != S_IDLE);
  assign timeout_cnt  = tcnt_q;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Directed bench for cordic_req_arbiter; the CORDIC is emulated inline with a
// fixed XOR transform so expected results are hand-computable constants.
module tb_cordic_req_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int T = 45;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, req_op;
  logic [N*W-1:0] req_angle;
  logic [N-1:0]   done;
  logic           err;
  logic [W-1:0]   result;
  logic           cordic_beg, cordic_op, cordic_ready, cordic_ack, busy;
  logic [W-1:0]   cordic_angle, cordic_result;
  logic [7:0]     timeout_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n;

  logic [31:0] ang [4] = '{32'h3F490FDB, 32'h11111111, 32'h22222222, 32'h33333333};
  logic [31:0] rc  [4] = '{32'h65135581, 32'hB4B4B4B4, 32'h78787878, 32'h96969696};
  int          ord [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  cordic_req_arbiter #(.N_REQ(N), .W(W), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_angle(req_angle),
    .done(done), .err(err), .result(result), .cordic_beg(cordic_beg),
    .cordic_op(cordic_op), .cordic_angle(cordic_angle), .cordic_ready(cordic_ready),
    .cordic_result(cordic_result), .cordic_ack(cordic_ack), .busy(busy),
    .timeout_cnt(timeout_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beg(input string tag, output int cnt);
    cnt = 0;
    while (!cordic_beg && cnt < 200) begin
      tick();
      cnt++;
    end
    chk({tag, " beg"}, 64'(cordic_beg), 64'd1);
  endtask

  // Entered in the ISSUE cycle; ready (if given) is seen lat cycles after beg.
  task automatic finish_txn(input string tag, input int lat, input bit give_ready,
                            input logic [3:0] exp_done, input logic exp_err,
                            input logic [31:0] exp_res);
    repeat (lat) tick();
    chk({tag, " pre-ack"}, {busy, cordic_ack, done}, {1'b1, 1'b0, 4'b0});
    if (give_ready) begin
      cordic_ready  = 1'b1;
      cordic_result = cordic_angle ^ (cordic_op ? 32'hA5A5A5A5 : 32'h5A5A5A5A);
    end
    tick();
    chk({tag, " ack"}, {cordic_ack, done}, {1'b1, 4'b0});
    cordic_ready  = 1'b0;
    cordic_result = 32'hDEADBEEF;
    tick();
    chk({tag, " done/err"}, {done, err}, {exp_done, exp_err});
    chk({tag, " result"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req = '0; req_op = '0; req_angle = '0;
    cordic_ready = 1'b0; cordic_result = '0;
    #12;
    chk("reset outs", {busy, cordic_beg, cordic_ack, done, err, cordic_op},
        {1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0});
    chk("reset data", {result, cordic_angle}, 64'd0);
    chk("reset tcnt", 64'(timeout_cnt), 64'd0);
    tick();
    reset = 1'b1;

    // single request, latency 40
    req_angle[0 +: 32] = ang[0];
    req = 4'b0001;
    wait_beg("single", n);
    chk("single beg latency", 64'(n), 64'd1);
    chk("single op/angle", {cordic_op, cordic_angle}, {1'b0, ang[0]});
    finish_txn("single", 40, 1'b1, 4'b0001, 1'b0, rc[0]);

    // fairness: all four held high continuously
    req_op = 4'b1010;
    for (int i = 1; i < 4; i++) req_angle[i*32 +: 32] = ang[i];
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_beg("fair", n);
      chk("fair gap", 64'(n), 64'd2);
      chk("fair angle", 64'(cordic_angle), 64'(ang[ord[k]]));
      finish_txn("fair", 3, 1'b1, 4'(1 << ord[k]), 1'b0, rc[ord[k]]);
    end

    // timeout on requester 2, result held from previous capture
    req = 4'b0100;
    req_op = 4'b0000;
    wait_beg("tmo", n);
    finish_txn("tmo", T, 1'b0, 4'b0100, 1'b1, rc[0]);
    chk("tmo cnt", 64'(timeout_cnt), 64'd1);
    wait_beg("post-tmo", n);
    finish_txn("post-tmo", 5, 1'b1, 4'b0100, 1'b0, rc[2]);
    chk("post-tmo cnt", 64'(timeout_cnt), 64'd1);

    // inputs change after grant are ignored
    req_angle[64 +: 32] = 32'h0BADF00D;
    req_op = 4'b0100;
    wait_beg("chg", n);
    chk("chg op/angle", {cordic_op, cordic_angle}, {1'b1, 32'h0BADF00D});
    tick();
    req_angle[64 +: 32] = 32'h12345678;
    req_op = 4'b0000;
    req = 4'b0000;
    tick();
    chk("chg angle kept", {cordic_op, cordic_angle}, {1'b1, 32'h0BADF00D});
    finish_txn("chg", 3, 1'b1, 4'b0100, 1'b0, 32'hAE0855A8);

    // ready on the same cycle the watchdog reaches TIMEOUT_CYC
    req_angle[0 +: 32] = 32'h40490FDB;
    req_op = 4'b1011;
    req = 4'b0001;
    wait_beg("coll", n);
    finish_txn("coll", T, 1'b1, 4'b0001, 1'b0, 32'hE5ECAA7E);
    chk("coll cnt", 64'(timeout_cnt), 64'd1);

    // reset mid-WAIT on requester 1's transaction
    req = 4'b0010;
    wait_beg("rst", n);
    chk("rst grant", 64'(cordic_angle), 64'(ang[1]));
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst outs", {busy, cordic_beg, cordic_ack, done, err}, {1'b0, 1'b0, 1'b0, 4'b0, 1'b0});
    chk("rst tcnt", 64'(timeout_cnt), 64'd0);
    chk("rst data", {result, cordic_angle}, 64'd0);
    tick();
    reset = 1'b1;
    req = 4'b0011;
    wait_beg("post-rst0", n);
    chk("post-rst0 latency", 64'(n), 64'd1);
    chk("post-rst0 angle", 64'(cordic_angle), 64'h40490FDB);
    finish_txn("post-rst0", 2, 1'b1, 4'b0001, 1'b0, 32'hE5ECAA7E);
    req = 4'b0010;
    wait_beg("post-rst1", n);
    chk("post-rst1 angle", 64'(cordic_angle), 64'(ang[1]));
    finish_txn("post-rst1", 2, 1'b1, 4'b0010, 1'b0, rc[1]);
    req = 4'b0000;
    tick();
    tick();
    chk("final idle", {busy, cordic_beg}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
